// File: rtl/alu_arbiter_if.sv
// Bundle between the two ALU requesters, the arbiter and the shared ALU.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if;
    logic        r0_req;
    logic [31:0] r0_a;
    logic [31:0] r0_b;
    logic [3:0]  r0_op;
    logic [4:0]  r0_shamt;
    logic        r0_gnt;
    logic        r0_valid;
    logic [31:0] r0_res;
    logic        r0_zero;
    logic        r0_ovf;

    logic        r1_req;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic [3:0]  r1_op;
    logic [4:0]  r1_shamt;
    logic        r1_gnt;
    logic        r1_valid;
    logic [31:0] r1_res;
    logic        r1_zero;
    logic        r1_ovf;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_ovf;
    logic        busy;

    modport slave (
        input  r0_req, r0_a, r0_b, r0_op, r0_shamt,
        output r0_gnt, r0_valid, r0_res, r0_zero, r0_ovf,
        input  r1_req, r1_a, r1_b, r1_op, r1_shamt,
        output r1_gnt, r1_valid, r1_res, r1_zero, r1_ovf,
        output alu_a, alu_b, alu_op, alu_shamt,
        input  alu_res, alu_zero, alu_ovf,
        output busy
    );

    modport master (
        output r0_req, r0_a, r0_b, r0_op, r0_shamt,
        input  r0_gnt, r0_valid, r0_res, r0_zero, r0_ovf,
        output r1_req, r1_a, r1_b, r1_op, r1_shamt,
        input  r1_gnt, r1_valid, r1_res, r1_zero, r1_ovf,
        input  alu_a, alu_b, alu_op, alu_shamt,
        output alu_res, alu_zero, alu_ovf,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU: grant in IDLE,
// one EXEC cycle, result written back to the owning requester.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t state;
    logic   ptr;    // requester favoured on a tie (round-robin only)
    logic   owner;  // requester whose operation is in flight
    logic   win;

    always_comb begin
        win = bus.r1_req;
        if (bus.r0_req && bus.r1_req)
            win = RR_EN ? ptr : 1'b0;
    end

    // NOTE: every register below uses <= so each branch reads pre-edge values;
    // rst is tested first so it overrides grants and write-backs in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            owner         <= 1'b0;
            bus.busy      <= 1'b0;
            bus.r0_gnt    <= 1'b0;
            bus.r1_gnt    <= 1'b0;
            bus.r0_valid  <= 1'b0;
            bus.r1_valid  <= 1'b0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.alu_shamt <= '0;
            bus.r0_res    <= '0;
            bus.r0_zero   <= 1'b0;
            bus.r0_ovf    <= 1'b0;
            bus.r1_res    <= '0;
            bus.r1_zero   <= 1'b0;
            bus.r1_ovf    <= 1'b0;
        end else begin
            bus.r0_gnt   <= 1'b0;
            bus.r1_gnt   <= 1'b0;
            bus.r0_valid <= 1'b0;
            bus.r1_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.r0_req || bus.r1_req) begin
                        bus.alu_a     <= win ? bus.r1_a     : bus.r0_a;
                        bus.alu_b     <= win ? bus.r1_b     : bus.r0_b;
                        bus.alu_op    <= win ? bus.r1_op    : bus.r0_op;
                        bus.alu_shamt <= win ? bus.r1_shamt : bus.r0_shamt;
                        bus.r0_gnt    <= ~win;
                        bus.r1_gnt    <= win;
                        owner         <= win;
                        ptr           <= ~win;
                        bus.busy      <= 1'b1;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner) begin
                        bus.r1_res   <= bus.alu_res;
                        bus.r1_zero  <= bus.alu_zero;
                        bus.r1_ovf   <= bus.alu_ovf;
                        bus.r1_valid <= 1'b1;
                    end else begin
                        bus.r0_res   <= bus.alu_res;
                        bus.r0_zero  <= bus.alu_zero;
                        bus.r0_ovf   <= bus.alu_ovf;
                        bus.r0_valid <= 1'b1;
                    end
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and
// compares both against a cycle-numbered transaction model of the arbitration rules.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req   [2];
    logic [31:0] a     [2];
    logic [31:0] b     [2];
    logic [3:0]  op    [2];
    logic [4:0]  shamt [2];

    alu_arbiter_if bus0 ();
    alu_arbiter_if bus1 ();

    alu_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(bus0));
    alu_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus1));

    // Shared ALU behaviour: returns {ovf, zero, res}.
    function automatic logic [33:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] o, input logic [4:0] sh);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (o)
            4'h0: r = x & y;
            4'h1: r = x | y;
            4'h2: begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
            4'h3: r = x ^ y;
            4'h4: r = x << sh;
            4'h5: r = x >> sh;
            4'h6: begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
            default: r = x ^ {y[15:0], y[31:16]};
        endcase
        return {v, (r == 32'd0), r};
    endfunction

    assign bus0.r0_req = req[0];   assign bus1.r0_req = req[0];
    assign bus0.r0_a = a[0];       assign bus1.r0_a = a[0];
    assign bus0.r0_b = b[0];       assign bus1.r0_b = b[0];
    assign bus0.r0_op = op[0];     assign bus1.r0_op = op[0];
    assign bus0.r0_shamt = shamt[0]; assign bus1.r0_shamt = shamt[0];
    assign bus0.r1_req = req[1];   assign bus1.r1_req = req[1];
    assign bus0.r1_a = a[1];       assign bus1.r1_a = a[1];
    assign bus0.r1_b = b[1];       assign bus1.r1_b = b[1];
    assign bus0.r1_op = op[1];     assign bus1.r1_op = op[1];
    assign bus0.r1_shamt = shamt[1]; assign bus1.r1_shamt = shamt[1];
    assign {bus0.alu_ovf, bus0.alu_zero, bus0.alu_res} =
        alu_fn(bus0.alu_a, bus0.alu_b, bus0.alu_op, bus0.alu_shamt);
    assign {bus1.alu_ovf, bus1.alu_zero, bus1.alu_res} =
        alu_fn(bus1.alu_a, bus1.alu_b, bus1.alu_op, bus1.alu_shamt);

    typedef struct packed {
        logic [1:0]  gnt;
        logic [1:0]  valid;
        logic        busy;
        logic [31:0] res0;
        logic [31:0] res1;
        logic [1:0]  zero;
        logic [1:0]  ovf;
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [3:0]  alu_op;
        logic [4:0]  alu_shamt;
    } obs_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    obs_t exp_s    [2];
    int   gnt_cyc  [2];  // cycle in which the latest grant pulse is visible
    int   ptr      [2];
    int   owner    [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    function automatic obs_t sample(input int m);
        obs_t o;
        if (m == 0) begin
            o.gnt   = {bus0.r1_gnt, bus0.r0_gnt};   o.valid = {bus0.r1_valid, bus0.r0_valid};
            o.busy  = bus0.busy;  o.res0 = bus0.r0_res;  o.res1 = bus0.r1_res;
            o.zero  = {bus0.r1_zero, bus0.r0_zero};  o.ovf = {bus0.r1_ovf, bus0.r0_ovf};
            o.alu_a = bus0.alu_a; o.alu_b = bus0.alu_b;
            o.alu_op = bus0.alu_op; o.alu_shamt = bus0.alu_shamt;
        end else begin
            o.gnt   = {bus1.r1_gnt, bus1.r0_gnt};   o.valid = {bus1.r1_valid, bus1.r0_valid};
            o.busy  = bus1.busy;  o.res0 = bus1.r0_res;  o.res1 = bus1.r1_res;
            o.zero  = {bus1.r1_zero, bus1.r0_zero};  o.ovf = {bus1.r1_ovf, bus1.r0_ovf};
            o.alu_a = bus1.alu_a; o.alu_b = bus1.alu_b;
            o.alu_op = bus1.alu_op; o.alu_shamt = bus1.alu_shamt;
        end
        return o;
    endfunction

    // Expected outputs for the cycle after the coming edge, from the current inputs.
    task automatic predict(input int m);
        obs_t        e;
        int          w;
        logic [33:0] r;
        e       = exp_s[m];
        e.gnt   = 2'b00;
        e.valid = 2'b00;
        if (rst) begin
            e          = '0;
            gnt_cyc[m] = -10;
            ptr[m]     = 0;
        end else if (cyc == gnt_cyc[m]) begin
            r = alu_fn(e.alu_a, e.alu_b, e.alu_op, e.alu_shamt);
            if (owner[m] == 1) e.res1 = r[31:0];
            else               e.res0 = r[31:0];
            e.zero[owner[m]]  = r[32];
            e.ovf[owner[m]]   = r[33];
            e.valid[owner[m]] = 1'b1;
            e.busy            = 1'b0;
        end else if (req[0] || req[1]) begin
            if (req[0] && req[1]) w = (m == 0) ? ptr[m] : 0;
            else                  w = req[1] ? 1 : 0;
            e.alu_a     = a[w];
            e.alu_b     = b[w];
            e.alu_op    = op[w];
            e.alu_shamt = shamt[w];
            e.gnt[w]    = 1'b1;
            e.busy      = 1'b1;
            owner[m]    = w;
            ptr[m]      = 1 - w;
            gnt_cyc[m]  = cyc + 1;
        end else begin
            e.busy = 1'b0;
        end
        exp_s[m] = e;
    endtask

    task automatic compare(input int m);
        obs_t  o;
        obs_t  e;
        string p;
        o = sample(m);
        e = exp_s[m];
        p = $sformatf("dut%0d cyc%0d", m, cyc);
        check({p, " gnt"},       64'(o.gnt),       64'(e.gnt));
        check({p, " valid"},     64'(o.valid),     64'(e.valid));
        check({p, " busy"},      64'(o.busy),      64'(e.busy));
        check({p, " r0_res"},    64'(o.res0),      64'(e.res0));
        check({p, " r1_res"},    64'(o.res1),      64'(e.res1));
        check({p, " zero"},      64'(o.zero),      64'(e.zero));
        check({p, " ovf"},       64'(o.ovf),       64'(e.ovf));
        check({p, " alu_a"},     64'(o.alu_a),     64'(e.alu_a));
        check({p, " alu_b"},     64'(o.alu_b),     64'(e.alu_b));
        check({p, " alu_op"},    64'(o.alu_op),    64'(e.alu_op));
        check({p, " alu_shamt"}, 64'(o.alu_shamt), 64'(e.alu_shamt));
    endtask

    task automatic step();
        predict(0);
        predict(1);
        @(posedge clk);
        #1;
        cyc++;
        compare(0);
        compare(1);
    endtask

    task automatic set_req(input int k, input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] o, input logic [4:0] s);
        req[k] = 1'b1; a[k] = x; b[k] = y; op[k] = o; shamt[k] = s;
    endtask

    initial begin
        logic [31:0] saved;
        logic [33:0] r;
        int          r1_fp;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; a[k] = '0; b[k] = '0; op[k] = '0; shamt[k] = '0;
            exp_s[k] = '0; gnt_cyc[k] = -10; ptr[k] = 0; owner[k] = 0;
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Single requester add
        set_req(0, 32'd5, 32'd3, 4'b0010, 5'd0);
        step();
        check("add gnt",  64'(bus0.r0_gnt), 64'd1);
        check("add busy", 64'(bus0.busy),   64'd1);
        req[0] = 1'b0;
        step();
        check("add valid", 64'(bus0.r0_valid), 64'd1);
        check("add res",   64'(bus0.r0_res),   64'd8);
        check("add busy0", 64'(bus0.busy),     64'd0);
        step();

        // Both requesters held from reset release
        rst = 1'b1;
        set_req(0, 32'd7, 32'd7, 4'b0110, 5'd0);
        set_req(1, 32'hF0, 32'h0F, 4'b0001, 5'd0);
        step();
        rst   = 1'b0;
        r1_fp = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus1.r1_gnt) r1_fp++;
            if (i == 3) begin
                check("rr r0_zero", 64'(bus0.r0_zero), 64'd1);
                check("rr r0_res",  64'(bus0.r0_res),  64'd0);
                check("rr r1_res",  64'(bus0.r1_res),  64'hFF);
            end
        end
        check("fixed r1 grants", 64'(r1_fp), 64'd0);

        // r1 requests during r0's EXEC cycle
        rst = 1'b1; req[0] = 1'b0; req[1] = 1'b0;
        step();
        rst = 1'b0;
        set_req(0, 32'd100, 32'd23, 4'b0010, 5'd0);
        step();
        req[0] = 1'b0;
        set_req(1, 32'd9, 32'd4, 4'b0110, 5'd0);
        step();
        saved = bus0.r0_res;
        check("late r0_res", 64'(saved), 64'd123);
        check("late no r1 gnt yet", 64'(bus0.r1_gnt), 64'd0);
        step();
        check("late r1_gnt", 64'(bus0.r1_gnt), 64'd1);
        req[1] = 1'b0;
        step();
        check("late r1_res", 64'(bus0.r1_res), 64'd5);
        check("late r0 kept", 64'(bus0.r0_res), 64'(saved));

        // Reset in the EXEC cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 32'd5, 32'd3, 4'b0010, 5'd0);
        step();
        rst = 1'b1; req[0] = 1'b0;
        step();
        check("rst exec valid", 64'(bus0.r0_valid), 64'd0);
        check("rst exec res",   64'(bus0.r0_res),   64'd0);
        rst = 1'b0;
        step();
        check("rst exec no late valid", 64'(bus0.r0_valid), 64'd0);

        // Undefined opcode forwarded
        set_req(1, 32'h1234_5678, 32'h0F0F_0F0F, 4'hF, 5'd3);
        step();
        check("undef alu_op", 64'(bus0.alu_op), 64'hF);
        req[1] = 1'b0;
        step();
        r = alu_fn(32'h1234_5678, 32'h0F0F_0F0F, 4'hF, 5'd3);
        check("undef r1_res", 64'(bus0.r1_res), 64'(r[31:0]));

        // Randomised traffic, requesters follow the round-robin DUT's grants
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < 2; k++) begin
                if (req[k] && ((k == 0) ? bus0.r0_gnt : bus0.r1_gnt)) begin
                    if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
                    else set_req(k, $urandom, $urandom, 4'($urandom), 5'($urandom));
                end else if (!req[k] && $urandom_range(0, 9) < 4) begin
                    set_req(k, $urandom, $urandom, 4'($urandom), 5'($urandom));
                end
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, arbitration mode: 1 round-robin, 0 fixed priority to requester 0.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 r0_req  input  1  requester 0 operation request, held high until r0_gnt is seen.
REQ-006 r0_a, r0_b  input  32 each  requester 0 operands.
REQ-007 r0_op  input  4  requester 0 ALU operation code, passed unmodified to alu_op.
REQ-008 r0_shamt  input  5  requester 0 shift amount.
REQ-009 r0_gnt  output  1  registered one-cycle pulse: requester 0 operands captured.
REQ-010 r0_valid  output  1  registered one-cycle pulse: r0_res, r0_zero, r0_ovf updated.
REQ-011 r0_res  output  32, r0_zero  output  1, r0_ovf  output  1  requester 0 result, zero and overflow flags; hold until next own completion.
REQ-012 r1_req, r1_a, r1_b, r1_op, r1_shamt, r1_gnt, r1_valid, r1_res, r1_zero, r1_ovf: same directions, widths and meanings for requester 1.
REQ-013 alu_a, alu_b  output  32 each  registered operands to the shared ALU.
REQ-014 alu_op  output  4, alu_shamt  output  5  registered operation and shift amount to the shared ALU.
REQ-015 alu_res  input  32, alu_zero  input  1, alu_ovf  input  1  combinational ALU result and flags.
REQ-016 busy  output  1  high while an operation is in flight (state EXEC).

Function
REQ-017 States: IDLE, EXEC; reset enters IDLE.
REQ-018 IDLE with at least one req high: capture winner's a/b/op/shamt into alu_a/alu_b/alu_op/alu_shamt at that edge, set winner's gnt for the next cycle, record owner, go to EXEC.
REQ-019 IDLE with no req: stay IDLE; ALU-facing outputs hold last values.
REQ-020 EXEC lasts exactly one cycle: at its closing edge capture alu_res/alu_zero/alu_ovf into owner's res/zero/ovf, pulse owner's valid for the next cycle, return to IDLE.
REQ-021 Latency: req first sampled high in IDLE at edge t -> gnt high in cycle t+1 -> valid high in cycle t+2 with result; peak throughput one operation per 2 cycles.
REQ-022 Requests sampled during EXEC are ignored; the requester keeps req high and is arbitrated in the next IDLE cycle.
REQ-023 Both req high in IDLE with RR_EN=1: priority pointer wins; after every grant the pointer moves to the other requester.
REQ-024 RR_EN=0: requester 0 always wins ties; pointer unused.
REQ-025 Single req high: that requester wins regardless of pointer; pointer still updates per REQ-023.
REQ-026 Non-owner res/zero/ovf and valid are never modified by another requester's completion.
REQ-027 gnt and valid are single-cycle pulses; r0_gnt and r1_gnt never high together; same for valid.
REQ-028 busy = (state == EXEC), registered.
REQ-029 Opcode values are not interpreted; undefined codes are forwarded as-is.

Reset
REQ-030 rst sampled high: state IDLE, pointer to requester 0, all gnt/valid/busy 0, alu_a/alu_b 0, alu_op 4'b0000, alu_shamt 0, all res 0, all zero/ovf flags 0.
REQ-031 rst during EXEC: in-flight operation discarded, no valid pulse, no result register update.
REQ-032 rst has priority over every other event in the same cycle.

Verification
REQ-033 r0 only, a=5, b=3, op=0010, ALU model adds -> r0_gnt cycle t+1, r0_valid cycle t+2, r0_res=8, r0_zero=0, busy high only in t+1.
REQ-034 Both req held high from reset release, RR_EN=1, r0 op=0110 a=b=7, r1 op=0001 a=0xF0 b=0x0F -> r0 served first (r0_res=0, r0_zero=1), r1 next (r1_res=0xFF), grants alternating every 2 cycles.
REQ-035 Same stimulus, RR_EN=0, r0 req kept high -> r1 never granted while r0_req stays high.
REQ-036 r1 raises req during r0's EXEC cycle -> r1_gnt exactly one cycle after r0 returns to IDLE; r0_res unchanged by r1 completion.
REQ-037 rst asserted in r0's EXEC cycle -> no r0_valid pulse, r0_res stays 0, all outputs at reset values next cycle.
REQ-038 op=1111 (undefined) from r1 -> alu_op=1111 during EXEC, r1_res equals model's alu_res.
